// File: rtl/axi_rom_burst_splitter_if.sv
//==============================================================================
// Module : axi_rom_burst_splitter_if
// Brief  : AXI4 five-channel bundle with master/slave views.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface axi_rom_burst_splitter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi_rom_burst_splitter.sv
//==============================================================================
// Module : axi_rom_burst_splitter
// Brief  : Splits AXI read bursts into single-beat ROM reads and answers all
//          writes locally with SLVERR. Define AXI_SPLIT_WRAP_EN to accept WRAP.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module axi_rom_burst_splitter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    axi_rom_burst_splitter_if.slave  axi,
    axi_rom_burst_splitter_if.master rom
);

    localparam int                SIZE_MAX     = $clog2(DATA_W / 8);
    localparam logic [1:0]        BURST_FIXED  = 2'b00;
    localparam logic [1:0]        BURST_INCR   = 2'b01;
    localparam logic [1:0]        BURST_WRAP   = 2'b10;
    localparam logic [1:0]        BURST_RSVD   = 2'b11;
    localparam logic [1:0]        RESP_OKAY    = 2'b00;
    localparam logic [1:0]        RESP_SLVERR  = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_ISSUE = 3'd1,
        R_WAIT  = 3'd2,
        R_RESP  = 3'd3,
        R_ERR   = 3'd4
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    rstate_t             rstate_q;
    logic [7:0]          cnt_q;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                arready_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic                rlast_q;
    logic                rom_arvalid_q;
    logic                rom_rready_q;

    wstate_t             wstate_q;
    logic                awready_q;
    logic                wready_q;
    logic                bvalid_q;
    logic [ID_W-1:0]     bid_q;

    logic                ar_illegal_d;
    logic [ADDR_W-1:0]   incr_d;
    logic [ADDR_W-1:0]   addr_nxt_d;

`ifdef AXI_SPLIT_WRAP_EN
    logic [7:0]          len_q;
    logic [ADDR_W-1:0]   wrap_mask_d;

    assign wrap_mask_d = ((({{(ADDR_W-8){1'b0}}, len_q}) + ADDR_ONE) << size_q) - ADDR_ONE;
`endif

    assign incr_d = ADDR_ONE << size_q;

    always_comb begin
        ar_illegal_d = 1'b0;
        if (axi.arsize > 3'(SIZE_MAX)) begin
            ar_illegal_d = 1'b1;
        end
        if (axi.arburst == BURST_RSVD) begin
            ar_illegal_d = 1'b1;
        end
        if (axi.arburst == BURST_WRAP) begin
`ifdef AXI_SPLIT_WRAP_EN
            if (!(axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
                ar_illegal_d = 1'b1;
            end
`else
            ar_illegal_d = 1'b1;
`endif
        end
    end

    always_comb begin
        addr_nxt_d = cur_addr_q;
        case (burst_q)
            BURST_FIXED: addr_nxt_d = cur_addr_q;
            BURST_INCR:  addr_nxt_d = cur_addr_q + incr_d;
`ifdef AXI_SPLIT_WRAP_EN
            // Only the offset inside the wrap window advances; the window base is kept.
            BURST_WRAP:  addr_nxt_d = (cur_addr_q & ~wrap_mask_d) |
                                      ((cur_addr_q + incr_d) & wrap_mask_d);
`endif
            default:     addr_nxt_d = cur_addr_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q      <= R_IDLE;
            cnt_q         <= 8'd0;
            id_q          <= '0;
            cur_addr_q    <= '0;
            size_q        <= 3'd0;
            burst_q       <= BURST_INCR;
            arready_q     <= 1'b1;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            rlast_q       <= 1'b0;
            rom_arvalid_q <= 1'b0;
            rom_rready_q  <= 1'b0;
`ifdef AXI_SPLIT_WRAP_EN
            len_q         <= 8'd0;
`endif
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (axi.arvalid && arready_q) begin
                        arready_q  <= 1'b0;
                        id_q       <= axi.arid;
                        cur_addr_q <= axi.araddr;
                        size_q     <= axi.arsize;
                        burst_q    <= axi.arburst;
                        cnt_q      <= axi.arlen;
`ifdef AXI_SPLIT_WRAP_EN
                        len_q      <= axi.arlen;
`endif
                        if (ar_illegal_d) begin
                            rvalid_q <= 1'b1;
                            rresp_q  <= RESP_SLVERR;
                            rdata_q  <= '0;
                            rlast_q  <= (axi.arlen == 8'd0);
                            rstate_q <= R_ERR;
                        end else begin
                            rom_arvalid_q <= 1'b1;
                            rstate_q      <= R_ISSUE;
                        end
                    end
                end
                R_ISSUE: begin
                    if (rom.arready) begin
                        rom_arvalid_q <= 1'b0;
                        rom_rready_q  <= 1'b1;
                        rstate_q      <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rom.rvalid) begin
                        rom_rready_q <= 1'b0;
                        rvalid_q     <= 1'b1;
                        rdata_q      <= rom.rdata;
                        rresp_q      <= rom.rresp;
                        rlast_q      <= (cnt_q == 8'd0);
                        rstate_q     <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (axi.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (cnt_q == 8'd0) begin
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            cnt_q         <= cnt_q - 8'd1;
                            cur_addr_q    <= addr_nxt_d;
                            rom_arvalid_q <= 1'b1;
                            rstate_q      <= R_ISSUE;
                        end
                    end
                end
                R_ERR: begin
                    if (axi.rready) begin
                        if (cnt_q == 8'd0) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            cnt_q   <= cnt_q - 8'd1;
                            rlast_q <= (cnt_q == 8'd1);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // The ROM is read-only: write bursts are drained and answered with SLVERR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (axi.awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        bid_q     <= axi.awid;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi.wvalid && axi.wlast) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        wstate_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rid     = id_q;
    assign axi.rlast   = rlast_q;
    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = RESP_SLVERR;
    assign axi.bid     = bid_q;

    assign rom.arvalid = rom_arvalid_q;
    assign rom.araddr  = cur_addr_q;
    assign rom.arid    = '0;
    assign rom.arlen   = 8'd0;
    assign rom.arsize  = size_q;
    assign rom.arburst = BURST_INCR;
    assign rom.rready  = rom_rready_q;
    assign rom.awid    = '0;
    assign rom.awaddr  = '0;
    assign rom.awlen   = 8'd0;
    assign rom.awsize  = 3'd0;
    assign rom.awburst = 2'b00;
    assign rom.awvalid = 1'b0;
    assign rom.wdata   = '0;
    assign rom.wstrb   = '0;
    assign rom.wlast   = 1'b0;
    assign rom.wvalid  = 1'b0;
    assign rom.bready  = 1'b0;

    logic w_unused;
    assign w_unused = ^{axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.wdata,
                        axi.wstrb, rom.awready, rom.wready, rom.bid, rom.bresp,
                        rom.bvalid, rom.rid, rom.rlast};

endmodule

`default_nettype wire

// File: tb/tb_axi_rom_burst_splitter.sv
//==============================================================================
// Module : tb_axi_rom_burst_splitter
// Brief  : Directed scoreboard bench with a single-cycle ROM model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_axi_rom_burst_splitter;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   t_ar = 0;
    int   beat_cyc [16];
    int   rom_ar_cnt = 0;
    int   rom_bad = 0;
    int   rom_wr_cnt = 0;

    beat_t       exp_q [$];
    logic [31:0] exp_addr_q [$];
    logic [31:0] rom_obs_q [$];

    axi_rom_burst_splitter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi_if ();
    axi_rom_burst_splitter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) rom_if ();

    axi_rom_burst_splitter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .axi (axi_if),
        .rom (rom_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM wrapper model: accepts every address, returns data one cycle later.
    assign rom_if.arready = 1'b1;
    assign rom_if.rresp   = 2'b00;
    assign rom_if.rid     = 4'd0;
    assign rom_if.rlast   = 1'b1;
    assign rom_if.awready = 1'b0;
    assign rom_if.wready  = 1'b0;
    assign rom_if.bid     = 4'd0;
    assign rom_if.bresp   = 2'b00;
    assign rom_if.bvalid  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_if.rvalid <= 1'b0;
            rom_if.rdata  <= 32'h0;
        end else if (rom_if.arvalid && rom_if.arready) begin
            rom_if.rvalid <= 1'b1;
            rom_if.rdata  <= rom_if.araddr ^ KEY;
            rom_obs_q.push_back(rom_if.araddr);
            rom_ar_cnt    <= rom_ar_cnt + 1;
            if (rom_if.arlen != 8'd0) rom_bad <= rom_bad + 1;
        end else if (rom_if.rvalid && rom_if.rready) begin
            rom_if.rvalid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rom_if.awvalid || rom_if.wvalid) rom_wr_cnt <= rom_wr_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_beat(input logic [31:0] addr, input logic [3:0] id,
                            input logic last, input logic ok);
        beat_t b;
        b.data = ok ? (addr ^ KEY) : 32'h0;
        b.resp = ok ? 2'b00 : 2'b10;
        b.id   = id;
        b.last = last;
        exp_q.push_back(b);
        if (ok) exp_addr_q.push_back(addr);
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int k;
        axi_if.arid    = id;
        axi_if.araddr  = addr;
        axi_if.arlen   = len;
        axi_if.arsize  = size;
        axi_if.arburst = burst;
        axi_if.arvalid = 1'b1;
        k = 0;
        while (!axi_if.arready && k < 40) begin tick(); k++; end
        check("ar_accept", axi_if.arready, 1'b1);
        t_ar = cyc;
        tick();
        axi_if.arvalid = 1'b0;
    endtask

    task automatic collect(input int n, input int stall_beat);
        beat_t e;
        int    k;
        int    c0;
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (!axi_if.rvalid && k < 40) begin tick(); k++; end
            check($sformatf("beat%0d_rvalid", i), axi_if.rvalid, 1'b1);
            if (!axi_if.rvalid) return;
            beat_cyc[i] = cyc;
            check($sformatf("beat%0d_sb_nonempty", i), exp_q.size() > 0, 1'b1);
            if (exp_q.size() == 0) return;
            e = exp_q.pop_front();
            check($sformatf("beat%0d_rdata", i), axi_if.rdata, e.data);
            check($sformatf("beat%0d_rresp", i), axi_if.rresp, e.resp);
            check($sformatf("beat%0d_rid", i),   axi_if.rid,   e.id);
            check($sformatf("beat%0d_rlast", i), axi_if.rlast, e.last);
            if (i == stall_beat) begin
                axi_if.rready = 1'b0;
                c0 = rom_ar_cnt;
                repeat (10) begin
                    tick();
                    check("stall_rvalid", axi_if.rvalid, 1'b1);
                    check("stall_rdata",  axi_if.rdata,  e.data);
                    check("stall_rid_rlast", {axi_if.rid, axi_if.rlast}, {e.id, e.last});
                end
                check("stall_no_rom_ar", rom_ar_cnt, c0);
                axi_if.rready = 1'b1;
            end
            tick();
        end
    endtask

    task automatic check_rom(input string tag);
        check({tag, "_rom_count"}, rom_obs_q.size(), exp_addr_q.size());
        while (rom_obs_q.size() > 0 && exp_addr_q.size() > 0) begin
            check({tag, "_rom_addr"}, rom_obs_q.pop_front(), exp_addr_q.pop_front());
        end
        rom_obs_q.delete();
        exp_addr_q.delete();
    endtask

    initial begin
        int c0;
        int k;
        axi_if.arid = 0; axi_if.araddr = 0; axi_if.arlen = 0; axi_if.arsize = 0;
        axi_if.arburst = 0; axi_if.arvalid = 0; axi_if.rready = 1;
        axi_if.awid = 0; axi_if.awaddr = 0; axi_if.awlen = 0; axi_if.awsize = 0;
        axi_if.awburst = 0; axi_if.awvalid = 0; axi_if.wdata = 0; axi_if.wstrb = 0;
        axi_if.wlast = 0; axi_if.wvalid = 0; axi_if.bready = 1;

        repeat (3) tick();
        check("rst_arready", axi_if.arready, 1'b1);
        check("rst_awready", axi_if.awready, 1'b1);
        check("rst_wready",  axi_if.wready,  1'b0);
        check("rst_rvalid",  axi_if.rvalid,  1'b0);
        check("rst_bvalid",  axi_if.bvalid,  1'b0);
        check("rst_rlast",   axi_if.rlast,   1'b0);
        check("rst_rdata",   axi_if.rdata,   32'h0);
        check("rst_rid_bid", {axi_if.rid, axi_if.bid}, 8'h00);
        check("rst_rom_arvalid", rom_if.arvalid, 1'b0);
        check("rst_rom_rready",  rom_if.rready,  1'b0);
        rst = 1'b0;
        tick();

        // INCR len 3 from 0x100
        exp_beat(32'h100, 4'd5, 1'b0, 1'b1);
        exp_beat(32'h104, 4'd5, 1'b0, 1'b1);
        exp_beat(32'h108, 4'd5, 1'b0, 1'b1);
        exp_beat(32'h10C, 4'd5, 1'b1, 1'b1);
        issue_ar(4'd5, 32'h100, 8'd3, 3'd2, 2'b01);
        collect(4, -1);
        check("incr_first_latency", beat_cyc[0] - t_ar, 3);
        check("incr_beat_spacing1", beat_cyc[1] - beat_cyc[0], 3);
        check("incr_beat_spacing3", beat_cyc[3] - beat_cyc[2], 3);
        check_rom("incr");
        check("incr_back_idle", axi_if.arready, 1'b1);

        // FIXED len 2 at 0x40
        exp_beat(32'h40, 4'd1, 1'b0, 1'b1);
        exp_beat(32'h40, 4'd1, 1'b0, 1'b1);
        exp_beat(32'h40, 4'd1, 1'b1, 1'b1);
        issue_ar(4'd1, 32'h40, 8'd2, 3'd2, 2'b00);
        collect(3, -1);
        check_rom("fixed");

        // Oversized arsize, then reserved burst type
        c0 = rom_ar_cnt;
        exp_beat(32'h0, 4'd3, 1'b0, 1'b0);
        exp_beat(32'h0, 4'd3, 1'b1, 1'b0);
        issue_ar(4'd3, 32'h0, 8'd1, 3'd3, 2'b01);
        collect(2, -1);
        check("badsize_no_rom", rom_ar_cnt, c0);
        exp_beat(32'h0, 4'd4, 1'b0, 1'b0);
        exp_beat(32'h0, 4'd4, 1'b1, 1'b0);
        issue_ar(4'd4, 32'h80, 8'd1, 3'd2, 2'b11);
        collect(2, -1);
        check("badburst_no_rom", rom_ar_cnt, c0);

        // Write: W arrives before AW and must be held off
        axi_if.wvalid = 1'b1;
        axi_if.wdata  = 32'h1234_5678;
        tick();
        check("w_before_aw_wready", axi_if.wready, 1'b0);
        axi_if.awid    = 4'd2;
        axi_if.awvalid = 1'b1;
        tick();
        axi_if.awvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            axi_if.wlast = (b == 3);
            k = 0;
            while (!axi_if.wready && k < 40) begin tick(); k++; end
            check("w_beat_ready", axi_if.wready, 1'b1);
            tick();
        end
        axi_if.wvalid = 1'b0;
        axi_if.wlast  = 1'b0;
        check("b_valid", axi_if.bvalid, 1'b1);
        check("b_resp",  axi_if.bresp,  2'b10);
        check("b_id",    axi_if.bid,    4'd2);
        tick();
        check("b_done", {axi_if.bvalid, axi_if.awready}, 2'b01);
        check("rom_no_write", rom_wr_cnt, 0);

        // INCR len 3 with upstream stall on beat 2
        exp_beat(32'h200, 4'd7, 1'b0, 1'b1);
        exp_beat(32'h204, 4'd7, 1'b0, 1'b1);
        exp_beat(32'h208, 4'd7, 1'b0, 1'b1);
        exp_beat(32'h20C, 4'd7, 1'b1, 1'b1);
        issue_ar(4'd7, 32'h200, 8'd3, 3'd2, 2'b01);
        collect(4, 1);
        check_rom("stall");

        // WRAP len 3 at 0x38
        c0 = rom_ar_cnt;
`ifdef AXI_SPLIT_WRAP_EN
        exp_beat(32'h38, 4'd9, 1'b0, 1'b1);
        exp_beat(32'h3C, 4'd9, 1'b0, 1'b1);
        exp_beat(32'h30, 4'd9, 1'b0, 1'b1);
        exp_beat(32'h34, 4'd9, 1'b1, 1'b1);
        issue_ar(4'd9, 32'h38, 8'd3, 3'd2, 2'b10);
        collect(4, -1);
        check_rom("wrap");
`else
        exp_beat(32'h0, 4'd9, 1'b0, 1'b0);
        exp_beat(32'h0, 4'd9, 1'b0, 1'b0);
        exp_beat(32'h0, 4'd9, 1'b0, 1'b0);
        exp_beat(32'h0, 4'd9, 1'b1, 1'b0);
        issue_ar(4'd9, 32'h38, 8'd3, 3'd2, 2'b10);
        collect(4, -1);
        check("wrap_no_rom", rom_ar_cnt, c0);
`endif

        // Asynchronous reset while waiting on the ROM
        issue_ar(4'd6, 32'h300, 8'd3, 3'd2, 2'b01);
        tick();
        check("pre_rst_in_wait", rom_if.rready, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_arready", axi_if.arready, 1'b1);
        check("arst_rvalid",  axi_if.rvalid,  1'b0);
        check("arst_rlast",   axi_if.rlast,   1'b0);
        check("arst_rdata",   axi_if.rdata,   32'h0);
        check("arst_rid",     axi_if.rid,     4'd0);
        check("arst_rom_arvalid", rom_if.arvalid, 1'b0);
        check("arst_rom_rready",  rom_if.rready,  1'b0);
        tick();
        rst = 1'b0;
        rom_obs_q.delete();
        tick();

        exp_beat(32'h500, 4'd3, 1'b1, 1'b1);
        issue_ar(4'd3, 32'h500, 8'd0, 3'd2, 2'b01);
        collect(1, -1);
        check_rom("post_rst");
        check("rom_arlen_zero", rom_bad, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
